// File: rtl/tt_um_wide_adder.sv
// Purpose: byte-serial wide adder/subtractor; A then B are streamed in LSB-first, result is read back LSB-first.
// Latency: the result is readable the cycle after the last B byte is accepted; one byte per strobed cycle in and out.
// Backpressure: none; strobes are level-sampled while ena=1, ready/res_valid tell the host which phase is active.
// Optional feature: define ADDER_SATURATE_EN for unsigned saturation of the stored result.
module tt_um_wide_adder #(
  parameter int WIDTH_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // A 1-byte configuration still needs a 1-bit index register.
  localparam int IDX_W = (WIDTH_BYTES > 1) ? $clog2(WIDTH_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           c_q, c_d;
  logic                           op_q, op_d;
  logic                           carry_q, carry_d;
  logic                           ovf_q, ovf_d;
  logic [WIDTH_BYTES-1:0][7:0]    a_q, a_d;
  logic [WIDTH_BYTES-1:0][7:0]    r_q, r_d;

  logic       start, wr_strobe, op_in, rd_strobe;
  logic       last;
  logic [IDX_W-1:0] idx_inc;
  logic [7:0] b_eff;
  logic [8:0] sum;
  logic       unused_ctrl;

  assign start     = uio_in[4];
  assign wr_strobe = uio_in[5];
  assign op_in     = uio_in[6];
  assign rd_strobe = uio_in[7];
  // Low nibble of uio_in carries no controls.
  assign unused_ctrl = &{1'b0, uio_in[3:0]};

  // Byte index wraps within the operand width so it never addresses past the last byte.
  assign last    = (idx_q == LAST_IDX);
  assign idx_inc = last ? '0 : idx_q + IDX_W'(1);

  // One byte lane of the ripple: subtraction adds ~B with the carry seeded to 1.
  assign b_eff = op_q ? ~ui_in : ui_in;
  assign sum   = {1'b0, a_q[idx_q]} + {1'b0, b_eff} + {8'b0, c_q};

  // Next-state and datapath update; everything holds unless ena is high.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    op_d    = op_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    r_d     = r_q;
    if (ena) begin
      if (start) begin
        // Start (from IDLE) or abort (from anywhere else); wins over both strobes.
        state_d = LOAD_A;
        op_d    = op_in;
        idx_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end else begin
        case (state_q)
          LOAD_A: begin
            if (wr_strobe) begin
              a_d[idx_q] = ui_in;
              idx_d      = idx_inc;
              if (last) begin
                state_d = LOAD_B;
                c_d     = op_q;
              end
            end
          end
          LOAD_B: begin
            if (wr_strobe) begin
              r_d[idx_q] = sum[7:0];
              c_d        = sum[8];
              idx_d      = idx_inc;
              if (last) begin
                state_d = OUT;
                carry_d = sum[8];
                ovf_d   = (a_q[idx_q][7] == b_eff[7]) && (sum[7] != a_q[idx_q][7]);
`ifdef ADDER_SATURATE_EN
                // Clamp to the unsigned range; flags keep the raw outcome.
                if (!op_q && sum[8]) begin
                  r_d = {WIDTH_BYTES{8'hFF}};
                end else if (op_q && !sum[8]) begin
                  r_d = '0;
                end
`endif
              end
            end
          end
          OUT: begin
            if (rd_strobe) begin
              idx_d = idx_inc;
              if (last) begin
                state_d = IDLE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // State register; reset discards any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      r_q     <= r_d;
    end
  end

  // Result byte is only exposed while the host is reading.
  assign uo_out  = (state_q == OUT) ? r_q[idx_q] : 8'h00;
  assign uio_out = {4'b0000, ovf_q, carry_q, (state_q == OUT),
                    (state_q == LOAD_A) || (state_q == LOAD_B)};
  assign uio_oe  = 8'b0000_1111;

endmodule

// File: tb/tb_tt_um_wide_adder.sv
// Directed bench for tt_um_wide_adder at WIDTH_BYTES=4.
// Hand-computed result bytes and status nibbles for add/sub, flags, reset and abort sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_tt_um_wide_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  logic s_start, s_wr, s_op, s_rd;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef ADDER_SATURATE_EN
  localparam logic [31:0] R31 = 32'hFFFF_FFFF;
  localparam logic [31:0] R32 = 32'h0000_0000;
`else
  localparam logic [31:0] R31 = 32'h0000_0000;
  localparam logic [31:0] R32 = 32'hFFFF_FFFE;
`endif

  tt_um_wide_adder #(.WIDTH_BYTES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Low nibble carries junk that the design must ignore.
  always_comb uio_in = {s_rd, s_op, s_wr, s_start, 4'hA};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a transaction, then drive the opposite op bit to prove it was latched.
  task automatic start_op(input logic op);
    s_start = 1'b1;
    s_op    = op;
    step();
    s_start = 1'b0;
    s_op    = ~op;
  endtask

  task automatic wr_word(input logic [31:0] w);
    s_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ui_in = w[8*i +: 8];
      step();
    end
    s_wr  = 1'b0;
    ui_in = 8'h5A;
  endtask

  // Reads all four bytes with rd held high; wr is also held to show it is ignored in OUT.
  task automatic read_chk(input string tag, input logic [31:0] e);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_rd%0d", tag, i), {24'b0, uo_out}, {24'b0, e[8*i +: 8]});
      s_rd = 1'b1;
      s_wr = 1'b1;
      step();
    end
    s_rd = 1'b0;
    s_wr = 1'b0;
  endtask

  task automatic run(input string tag, input logic op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] r, input logic [7:0] flags);
    start_op(op);
    chk({tag, "_ready_a"}, {24'b0, uio_out}, 32'h01);
    wr_word(a);
    chk({tag, "_ready_b"}, {24'b0, uio_out}, 32'h01);
    wr_word(b);
    chk({tag, "_out_stat"}, {24'b0, uio_out}, {24'b0, flags | 8'h02});
    read_chk(tag, r);
    chk({tag, "_idle_stat"}, {24'b0, uio_out}, {24'b0, flags});
    chk({tag, "_idle_uo"}, {24'b0, uo_out}, 32'h0);
  endtask

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b1;
    ui_in   = 8'h00;
    s_start = 1'b0;
    s_wr    = 1'b0;
    s_op    = 1'b0;
    s_rd    = 1'b0;
    step();
    step();
    chk("rst_uo", {24'b0, uo_out}, 32'h0);
    chk("rst_uio", {24'b0, uio_out}, 32'h0);
    chk("rst_oe", {24'b0, uio_oe}, 32'h0F);
    rst_n = 1'b1;
    step();
    chk("idle_uio", {24'b0, uio_out}, 32'h0);

    run("t30", 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 8'h00);
    run("t31", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, R31,           8'h04);
    run("t32", 1'b1, 32'h0000_0005, 32'h0000_0007, R32,           8'h00);
    run("t33", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 8'h08);
    run("sub_nb", 1'b1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 8'h04);
    run("sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 8'h0C);

    // Reset in the middle of LOAD_B after B byte 2.
    start_op(1'b0);
    wr_word(32'h0000_0001);
    s_wr  = 1'b1;
    ui_in = 8'h02;
    step();
    ui_in = 8'h00;
    step();
    step();
    s_wr = 1'b0;
    chk("t34_pre_ready", {24'b0, uio_out}, 32'h01);
    rst_n = 1'b0;
    #1;
    chk("t34_rst_uo", {24'b0, uo_out}, 32'h0);
    chk("t34_rst_uio", {24'b0, uio_out}, 32'h0);
    step();
    rst_n = 1'b1;
    s_rd  = 1'b1;
    step();
    s_rd = 1'b0;
    chk("t34_no_partial_uo", {24'b0, uo_out}, 32'h0);
    chk("t34_no_partial_uio", {24'b0, uio_out}, 32'h0);
    run("t34_fresh", 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 8'h00);

    // Abort from OUT with a simultaneous write, then an ena=0 pause inside LOAD_A.
    run("t35_prev", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, R31, 8'h04);
    start_op(1'b0);
    wr_word(32'h0000_0001);
    wr_word(32'h0000_0002);
    chk("t35_rd0", {24'b0, uo_out}, 32'h03);
    s_rd = 1'b1;
    step();
    s_rd    = 1'b0;
    s_start = 1'b1;
    s_wr    = 1'b1;
    s_op    = 1'b0;
    ui_in   = 8'h55;
    step();
    s_start = 1'b0;
    s_wr    = 1'b0;
    s_op    = 1'b1;
    chk("t35_abort_stat", {24'b0, uio_out}, 32'h01);
    chk("t35_abort_uo", {24'b0, uo_out}, 32'h0);
    s_wr  = 1'b1;
    ui_in = 8'h10;
    step();
    ena     = 1'b0;
    ui_in   = 8'hEE;
    s_start = 1'b1;
    s_rd    = 1'b1;
    step();
    step();
    step();
    chk("t35_ena_hold", {24'b0, uio_out}, 32'h01);
    ena     = 1'b1;
    s_start = 1'b0;
    s_rd    = 1'b0;
    ui_in   = 8'h20;
    step();
    ui_in = 8'h30;
    step();
    ui_in = 8'h40;
    step();
    s_wr = 1'b0;
    chk("t35_ready_b", {24'b0, uio_out}, 32'h01);
    wr_word(32'h0102_0304);
    chk("t35_out_stat", {24'b0, uio_out}, 32'h02);
    read_chk("t35", 32'h4132_2314);
    chk("t35_idle_stat", {24'b0, uio_out}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_wide_adder.md
TT_UM_WIDE_ADDER -- requirements
Module: tt_um_wide_adder

Interface
REQ-001 Parameter WIDTH_BYTES, default 4, sets the operand/result width in bytes; legal range 1..16.
REQ-002 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 ena  input  1  design enable; when low, all state SHALL hold.
REQ-005 ui_in  input  8  operand data byte, LSB-first.
REQ-006 uio_in  input  8  bits [7:4] are controls: [4] start, [5] wr_strobe, [6] op (0=add, 1=sub), [7] rd_strobe; bits [3:0] are ignored.
REQ-007 uo_out  output  8  current result byte.
REQ-008 uio_out  output  8  bits [3:0] are status: [0] ready, [1] res_valid, [2] carry, [3] ovf; bits [7:4] are driven 0.
REQ-009 uio_oe  output  8  SHALL be constant 8'b0000_1111.

Function
REQ-010 States: IDLE, LOAD_A, LOAD_B, OUT; all transitions require ena=1 at the clock edge.
REQ-011 IDLE with start=1 -> LOAD_A; op is latched on this edge; the byte index clears to 0.
REQ-012 LOAD_A: each edge with wr_strobe=1 stores ui_in as A byte[index] and increments the index; after byte WIDTH_BYTES-1 -> LOAD_B with index 0.
REQ-013 LOAD_B: each edge with wr_strobe=1 computes R[index] = A[index] + (op ? ~ui_in : ui_in) + c, then updates c to the byte carry-out; the carry register c initialises to op on entry to LOAD_B.
REQ-014 LOAD_B: after the last byte -> OUT with index 0; carry flag = final c; ovf = signed overflow of the MSB byte (operand sign bits equal, result sign differs, taking the effective B as inverted for sub).
REQ-015 OUT: uo_out = R[index]; each edge with rd_strobe=1 increments the index; the read of the last byte -> IDLE.
REQ-016 uo_out SHALL be 0 in every state other than OUT.
REQ-017 ready=1 in LOAD_A and LOAD_B; otherwise 0.
REQ-018 res_valid=1 only in OUT.
REQ-019 carry and ovf hold their values from LOAD_B exit until the next entry to LOAD_A, which clears both.
REQ-020 For sub, carry=1 means no borrow (A>=B unsigned).
REQ-021 start=1 in any non-IDLE state aborts: -> LOAD_A, op relatched, index 0, flags cleared; start takes priority over both strobes on the same edge.
REQ-022 wr_strobe in IDLE or OUT, and rd_strobe outside OUT, SHALL be ignored.
REQ-023 Strobes are level-sampled; a strobe held high accepts one byte per cycle.
REQ-024 Byte-index arithmetic is modulo WIDTH_BYTES; no out-of-range access is permitted.

Reset
REQ-025 rst_n=0 immediately forces IDLE with index, c, op, carry, ovf, A and R all at 0.
REQ-026 While rst_n=0: uo_out=0 and uio_out=0.
REQ-027 Reset asserted mid-operation discards the transaction; no partial result is readable afterwards.

Configuration
REQ-028 Macro ADDER_SATURATE_EN, when defined, enables unsigned saturation: on OUT entry, add with carry=1 forces every R byte to 8'hFF, and sub with carry=0 forces every R byte to 8'h00; carry and ovf still report the raw values.
REQ-029 Without ADDER_SATURATE_EN, R holds the wrapped modulo-2^(8*WIDTH_BYTES) result and no saturation logic is present.

Verification (WIDTH_BYTES=4)
REQ-030 add 0x000000FF + 0x00000001 -> reads 00,01,00,00; carry=0, ovf=0.
REQ-031 add 0xFFFFFFFF + 0x00000001 -> reads 00 x4 with carry=1; with ADDER_SATURATE_EN, reads FF x4 with carry=1.
REQ-032 sub 0x00000005 - 0x00000007 -> reads FE,FF,FF,FF with carry=0; with ADDER_SATURATE_EN, reads 00 x4.
REQ-033 add 0x7FFFFFFF + 0x00000001 -> reads 00,00,00,80; ovf=1, carry=0.
REQ-034 Interrupt sequence: rst_n low after B byte 2 -> uo_out=0, uio_out=0, ready=0 at once; a fresh add 1+2 then reads 03,00,00,00.
REQ-035 Interrupt sequence: start=1 with wr_strobe=1 in OUT after one byte read -> LOAD_A, flags=0; the data byte is not stored; ena=0 for 3 cycles mid-LOAD_A changes no state.
